// File: rtl/pe_multicast_ctrl_if.sv
// ---------------------------------------------------------------------------
// pe_multicast_ctrl_if
//  Bundles the configuration port, the shared tagged data bus, the PE load
//  port and the status outputs of one multicast receiver.
//  Modports:
//   slave  - the receiver (pe_multicast_ctrl) side
//   master - the driving side (bus, configuration source and PE model)
//  Signals:
//   cfg_enable/cfg_id                 ID register load
//   in_valid/in_tag/in_data/in_ready  tagged bus handshake
//   pe_ready/pe_enable/pe_data        PE load handshake
//   word_count/burst_done             burst progress
// ---------------------------------------------------------------------------
interface pe_multicast_ctrl_if #(
   parameter int unsigned BITWIDTH  = 16,
   parameter int unsigned ID_WIDTH  = 4,
   parameter int unsigned CNT_WIDTH = 3
) ();

   logic                       cfg_enable;
   logic [ID_WIDTH-1:0]        cfg_id;
   logic                       in_valid;
   logic [ID_WIDTH-1:0]        in_tag;
   logic signed [BITWIDTH-1:0] in_data;
   logic                       in_ready;
   logic                       pe_ready;
   logic                       pe_enable;
   logic signed [BITWIDTH-1:0] pe_data;
   logic [CNT_WIDTH-1:0]       word_count;
   logic                       burst_done;

   modport slave (
      input  cfg_enable, cfg_id, in_valid, in_tag, in_data, pe_ready,
      output in_ready, pe_enable, pe_data, word_count, burst_done
   );

   modport master (
      output cfg_enable, cfg_id, in_valid, in_tag, in_data, pe_ready,
      input  in_ready, pe_enable, pe_data, word_count, burst_done
   );

endinterface

// File: rtl/pe_multicast_ctrl.sv
// ---------------------------------------------------------------------------
// pe_multicast_ctrl
//  Tag-matched multicast receiver in front of one PE ifmap/filter load port.
//  Captures bus words tagged with its own ID or the all-ones broadcast tag
//  into a one-word holding register, hands them to the PE only while the PE
//  is ready, counts delivered words and pulses burst_done on the last word
//  of every BURST_LEN-word burst.
//  Ports:
//   clk   - rising-edge clock
//   rstb  - asynchronous active-low reset
//   bus   - pe_multicast_ctrl_if.slave (config, tagged bus, PE load, status)
// ---------------------------------------------------------------------------
module pe_multicast_ctrl #(
   parameter int unsigned BITWIDTH  = 16,
   parameter int unsigned ID_WIDTH  = 4,
   parameter int unsigned BURST_LEN = 3,
   parameter int unsigned CNT_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  rstb,
   pe_multicast_ctrl_if.slave    bus
);

   localparam logic [ID_WIDTH-1:0]  BCAST_TAG = {ID_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0] LAST_IDX  = CNT_WIDTH'(BURST_LEN - 1);

   typedef enum logic [0:0] {StEmpty, StFull} state_e;

   state_e                     r_state;
   state_e                     w_state_nxt;
   logic [ID_WIDTH-1:0]        r_id;
   logic signed [BITWIDTH-1:0] r_pe_data;
   logic signed [BITWIDTH-1:0] w_pe_data_nxt;
   logic [CNT_WIDTH-1:0]       r_word_count;
   logic [CNT_WIDTH-1:0]       w_word_count_nxt;
   logic                       r_burst_done;
   logic                       w_burst_done_nxt;

   logic w_hold_valid;
   logic w_match;
   logic w_deliver;
   logic w_in_ready;
   logic w_accept;
   logic w_load;

   // Match uses the ID as it stood before any same-cycle reconfiguration.
   assign w_match      = (bus.in_tag == r_id) | (bus.in_tag == BCAST_TAG);
   assign w_hold_valid = (r_state == StFull);
   assign w_deliver    = w_hold_valid & bus.pe_ready;
   // A word being delivered this cycle frees the register for a new one.
   assign w_in_ready   = ~w_hold_valid | bus.pe_ready;
   assign w_accept     = bus.in_valid & w_in_ready;
   assign w_load       = w_accept & w_match;

   always_comb begin
      w_state_nxt      = r_state;
      w_pe_data_nxt    = r_pe_data;
      w_word_count_nxt = r_word_count;
      w_burst_done_nxt = 1'b0;

      unique case (r_state)
         StEmpty: if (w_load) w_state_nxt = StFull;
         StFull: begin
            if (w_load)         w_state_nxt = StFull;
            else if (w_deliver) w_state_nxt = StEmpty;
         end
      endcase

      if (w_load) w_pe_data_nxt = bus.in_data;

      if (w_deliver) begin
         if (r_word_count == LAST_IDX) begin
            w_word_count_nxt = '0;
            w_burst_done_nxt = 1'b1;
         end else begin
            w_word_count_nxt = r_word_count + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         r_state      <= StEmpty;
         r_id         <= '0;
         r_pe_data    <= '0;
         r_word_count <= '0;
         r_burst_done <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_pe_data    <= w_pe_data_nxt;
         r_word_count <= w_word_count_nxt;
         r_burst_done <= w_burst_done_nxt;
         if (bus.cfg_enable) r_id <= bus.cfg_id;
      end
   end

   assign bus.in_ready   = w_in_ready;
   assign bus.pe_enable  = w_deliver;
   assign bus.pe_data    = r_pe_data;
   assign bus.word_count = r_word_count;
   assign bus.burst_done = r_burst_done;

endmodule

// File: tb/tb_pe_multicast_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pe_multicast_ctrl
//  Directed bench for pe_multicast_ctrl: tag filtering, back-pressure hold,
//  burst counting, same-cycle reconfiguration, reset mid-transfer and a
//  randomised in_valid/pe_ready ordering run against a sent-word queue.
// ---------------------------------------------------------------------------
module tb_pe_multicast_ctrl;

   logic clk;
   logic rstb;

   pe_multicast_ctrl_if #(.BITWIDTH(16), .ID_WIDTH(4), .CNT_WIDTH(3)) bus ();

   pe_multicast_ctrl #(
      .BITWIDTH (16),
      .ID_WIDTH (4),
      .BURST_LEN(3),
      .CNT_WIDTH(3)
   ) u_dut (
      .clk (clk),
      .rstb(rstb),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Delivery log: PE-side words, their cycle stamps, and burst_done positions
   // expressed as the number of words delivered before the pulse cycle.
   int          cyc = 0;
   logic [15:0] dlv_q[$];
   int          dlv_cyc_q[$];
   int          bd_q[$];

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (bus.burst_done) bd_q.push_back(dlv_q.size());
      if (bus.pe_enable) begin
         dlv_q.push_back(bus.pe_data);
         dlv_cyc_q.push_back(cyc);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      dlv_q.delete();
      dlv_cyc_q.delete();
      bd_q.delete();
   endtask

   task automatic idle_inputs();
      bus.cfg_enable = 1'b0;
      bus.cfg_id     = '0;
      bus.in_valid   = 1'b0;
      bus.in_tag     = '0;
      bus.in_data    = '0;
   endtask

   task automatic do_reset();
      step();
      idle_inputs();
      rstb = 1'b0;
      step();
      step();
      rstb = 1'b1;
      clear_logs();
   endtask

   task automatic cfg(input logic [3:0] id);
      bus.cfg_enable = 1'b1;
      bus.cfg_id     = id;
      step();
      bus.cfg_enable = 1'b0;
   endtask

   task automatic send(input logic [3:0] tag, input logic [15:0] data);
      bus.in_valid = 1'b1;
      bus.in_tag   = tag;
      bus.in_data  = data;
      step();
      bus.in_valid = 1'b0;
   endtask

   logic [15:0] exp_q[$];
   logic [15:0] w_data;
   logic [3:0]  w_tag;
   int          sent;
   int          budget;
   int          seq_err;
   logic [15:0] t3_exp[6];

   initial begin
      rstb         = 1'b0;
      bus.pe_ready = 1'b0;
      idle_inputs();
      #12;
      // Reset state
      check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("rst_pe_enable", {31'd0, bus.pe_enable}, 32'd0);
      check("rst_word_count", {29'd0, bus.word_count}, 32'd0);
      check("rst_burst_done", {31'd0, bus.burst_done}, 32'd0);
      check("rst_pe_data", {16'd0, bus.pe_data}, 32'd0);

      // 1: tag filter, broadcast accepted, foreign tag dropped
      do_reset();
      bus.pe_ready = 1'b1;
      cfg(4'd5);
      send(4'd5, 16'd10);
      send(4'd3, 16'd20);
      send(4'd15, 16'd30);
      repeat (3) step();
      check("t1_count", dlv_q.size(), 32'd2);
      if (dlv_q.size() == 2) begin
         check("t1_word0", {16'd0, dlv_q[0]}, 32'd10);
         check("t1_word1", {16'd0, dlv_q[1]}, 32'd30);
      end
      check("t1_word_count", {29'd0, bus.word_count}, 32'd2);
      check("t1_no_burst", bd_q.size(), 32'd0);

      // 2: hold under back-pressure, single delivery on pe_ready
      do_reset();
      bus.pe_ready = 1'b0;
      cfg(4'd2);
      send(4'd2, 16'hFFF9);
      #1;
      check("t2_in_ready_full", {31'd0, bus.in_ready}, 32'd0);
      check("t2_stall_enable", {31'd0, bus.pe_enable}, 32'd0);
      repeat (3) step();
      check("t2_stall_enable_late", {31'd0, bus.pe_enable}, 32'd0);
      step();
      bus.pe_ready = 1'b1;
      #1;
      check("t2_enable", {31'd0, bus.pe_enable}, 32'd1);
      check("t2_data", {16'd0, bus.pe_data}, 32'h0000FFF9);
      check("t2_in_ready_pass", {31'd0, bus.in_ready}, 32'd1);
      step();
      check("t2_enable_drop", {31'd0, bus.pe_enable}, 32'd0);
      step();
      check("t2_count", dlv_q.size(), 32'd1);
      check("t2_word_count", {29'd0, bus.word_count}, 32'd1);

      // 3: six back-to-back words, two bursts
      do_reset();
      bus.pe_ready = 1'b1;
      cfg(4'd6);
      for (int i = 0; i < 6; i++) begin
         t3_exp[i] = 16'(16'd100 + 16'(i));
         bus.in_valid = 1'b1;
         bus.in_tag   = 4'd6;
         bus.in_data  = t3_exp[i];
         step();
      end
      bus.in_valid = 1'b0;
      repeat (3) step();
      check("t3_count", dlv_q.size(), 32'd6);
      if (dlv_q.size() == 6) begin
         seq_err = 0;
         for (int i = 0; i < 6; i++) begin
            if (dlv_q[i] !== t3_exp[i]) seq_err++;
            if (dlv_cyc_q[i] - dlv_cyc_q[0] != i) seq_err++;
         end
         check("t3_seq_consecutive", seq_err, 32'd0);
      end
      check("t3_burst_pulses", bd_q.size(), 32'd2);
      if (bd_q.size() == 2) begin
         check("t3_burst0_after", bd_q[0], 32'd3);
         check("t3_burst1_after", bd_q[1], 32'd6);
      end
      check("t3_word_count_wrap", {29'd0, bus.word_count}, 32'd0);

      // 4: same-cycle reconfiguration matches against the old ID
      do_reset();
      bus.pe_ready = 1'b1;
      cfg(4'd1);
      bus.cfg_enable = 1'b1;
      bus.cfg_id     = 4'd4;
      send(4'd4, 16'h0044);
      bus.cfg_enable = 1'b0;
      send(4'd4, 16'h0055);
      repeat (2) step();
      check("t4_count", dlv_q.size(), 32'd1);
      if (dlv_q.size() == 1) check("t4_word", {16'd0, dlv_q[0]}, 32'h55);

      // 5: reset while FULL discards the word and clears the ID
      do_reset();
      bus.pe_ready = 1'b0;
      cfg(4'd4);
      send(4'd4, 16'h0077);
      send(4'd4, 16'h0066);
      check("t5_full", {31'd0, bus.in_ready}, 32'd0);
      rstb = 1'b0;
      bus.pe_ready = 1'b1;
      #1;
      check("t5_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("t5_rst_enable", {31'd0, bus.pe_enable}, 32'd0);
      check("t5_rst_word_count", {29'd0, bus.word_count}, 32'd0);
      step();
      rstb = 1'b1;
      repeat (3) step();
      check("t5_no_stale", dlv_q.size(), 32'd0);
      send(4'd4, 16'h0088);
      send(4'd0, 16'h0099);
      repeat (2) step();
      check("t5_id_zero_count", dlv_q.size(), 32'd1);
      if (dlv_q.size() == 1) check("t5_id_zero_word", {16'd0, dlv_q[0]}, 32'h99);

      // 6: random handshake timing, ordering against the accepted-word queue
      do_reset();
      exp_q.delete();
      sent   = 0;
      budget = 20000;
      w_data = 16'($urandom);
      w_tag  = 4'd0;
      while (sent < 1000 && budget > 0) begin
         bus.pe_ready = ($urandom_range(0, 3) != 0);
         bus.in_valid = ($urandom_range(0, 3) != 0);
         bus.in_tag   = w_tag;
         bus.in_data  = w_data;
         #1;
         if (bus.in_valid && bus.in_ready) begin
            sent++;
            if (w_tag == 4'd0 || w_tag == 4'd15) exp_q.push_back(w_data);
            w_data = 16'($urandom);
            case ($urandom_range(0, 7))
               0:       w_tag = 4'd15;
               1:       w_tag = 4'($urandom_range(1, 14));
               default: w_tag = 4'd0;
            endcase
         end
         step();
         budget--;
      end
      check("t6_budget", {31'd0, (sent == 1000)}, 32'd1);
      bus.in_valid = 1'b0;
      bus.pe_ready = 1'b1;
      repeat (3) step();
      check("t6_count", dlv_q.size(), exp_q.size());
      seq_err = 0;
      for (int i = 0; i < exp_q.size() && i < dlv_q.size(); i++) begin
         if (dlv_q[i] !== exp_q[i]) seq_err++;
      end
      check("t6_sequence", seq_err, 32'd0);
      check("t6_bursts", bd_q.size(), 32'(exp_q.size() / 3));
      check("t6_word_count", {29'd0, bus.word_count}, 32'(exp_q.size() % 3));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
